// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_if
// Purpose  : Decode/writeback bundle for regfile_sb: reads, write, reservation,
//            clear request, read data, pending flags and busy.
// Revision : 1.0
// ============================================================================
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              i_clr;
    logic [ADDR_W-1:0] i_raddr1;
    logic [ADDR_W-1:0] i_raddr2;
    logic [ADDR_W-1:0] i_waddr;
    logic [DATA_W-1:0] i_wdata;
    logic              i_we;
    logic              i_rsv_en;
    logic [ADDR_W-1:0] i_rsv_addr;
    logic [DATA_W-1:0] o_rdata1;
    logic [DATA_W-1:0] o_rdata2;
    logic              o_pend1;
    logic              o_pend2;
    logic              o_busy;

    modport master (
        output i_clr, i_raddr1, i_raddr2, i_waddr, i_wdata, i_we, i_rsv_en, i_rsv_addr,
        input  o_rdata1, o_rdata2, o_pend1, o_pend2, o_busy
    );

    modport slave (
        input  i_clr, i_raddr1, i_raddr2, i_waddr, i_wdata, i_we, i_rsv_en, i_rsv_addr,
        output o_rdata1, o_rdata2, o_pend1, o_pend2, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : 2R/1W register file with clear sequencer and pending-write
//            scoreboard. Optional macro REGFILE_SB_BYPASS_EN: write-to-read forwarding.
// Revision : 1.0
// ============================================================================
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] c_CNT_START = (ADDR_W+1)'(ZERO_REG);
    localparam logic [ADDR_W:0] c_CNT_LAST  = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W:0]   cnt_q;
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              busy_q;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic idle;
    logic wr_ok;
    assign idle  = (state_q == S_IDLE);
    assign wr_ok = bus.i_we && !((ZERO_REG != 0) && (bus.i_waddr == '0));

    // Reservation is applied after the writeback clear so a same-address set wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok)
            pend_d[bus.i_waddr] = 1'b0;
        if (bus.i_rsv_en)
            pend_d[bus.i_rsv_addr] = 1'b1;
        if (ZERO_REG != 0)
            pend_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= c_CNT_START;
            pend_q  <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_clr) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= c_CNT_START;
                        pend_q  <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        pend_q  <= pend_d;
                    end
                end
                S_CLEAR: begin
                    if (cnt_q == c_CNT_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    cnt_q <= cnt_q + (ADDR_W+1)'(1);
                end
            endcase
        end
    end

    // Storage has no reset; the clear sequencer is what initialises it.
    always_ff @(posedge i_clk) begin
        if (!idle)
            regs_q[cnt_q[ADDR_W-1:0]] <= '0;
        else if (wr_ok)
            regs_q[bus.i_waddr] <= bus.i_wdata;
    end

    always_comb begin
        bus.o_rdata1 = regs_q[bus.i_raddr1];
        bus.o_pend1  = pend_q[bus.i_raddr1];
`ifdef REGFILE_SB_BYPASS_EN
        if (wr_ok && (bus.i_waddr == bus.i_raddr1)) begin
            bus.o_rdata1 = bus.i_wdata;
            bus.o_pend1  = bus.i_rsv_en && (bus.i_rsv_addr == bus.i_raddr1);
        end
`endif
        if (!idle || ((ZERO_REG != 0) && (bus.i_raddr1 == '0))) begin
            bus.o_rdata1 = '0;
            bus.o_pend1  = 1'b0;
        end
    end

    always_comb begin
        bus.o_rdata2 = regs_q[bus.i_raddr2];
        bus.o_pend2  = pend_q[bus.i_raddr2];
`ifdef REGFILE_SB_BYPASS_EN
        if (wr_ok && (bus.i_waddr == bus.i_raddr2)) begin
            bus.o_rdata2 = bus.i_wdata;
            bus.o_pend2  = bus.i_rsv_en && (bus.i_rsv_addr == bus.i_raddr2);
        end
`endif
        if (!idle || ((ZERO_REG != 0) && (bus.i_raddr2 == '0))) begin
            bus.o_rdata2 = '0;
            bus.o_pend2  = 1'b0;
        end
    end

    assign bus.o_busy = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb against an array/countdown model.
// Revision : 1.0
// ============================================================================
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int CLR_CYCLES = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] mdl_mem  [DEPTH];
    bit                mdl_pend [DEPTH];
    int                mdl_clear_left;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i]  = '0;
            mdl_pend[i] = 1'b0;
        end
        mdl_clear_left = CLR_CYCLES;
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (mdl_clear_left > 0 || a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
        if (bus.i_we && bus.i_waddr == a) return bus.i_wdata;
`endif
        return mdl_mem[a];
    endfunction

    function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
        if (mdl_clear_left > 0 || a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        if (bus.i_we && bus.i_waddr == a) return bus.i_rsv_en && (bus.i_rsv_addr == a);
`endif
        return mdl_pend[a];
    endfunction

    task automatic mdl_edge();
        if (!rst_n) begin
            mdl_reset();
        end else if (mdl_clear_left > 0) begin
            mdl_clear_left--;
        end else if (bus.i_clr) begin
            mdl_reset();
        end else begin
            if (bus.i_we && bus.i_waddr != 0) begin
                mdl_mem[bus.i_waddr]  = bus.i_wdata;
                mdl_pend[bus.i_waddr] = 1'b0;
            end
            if (bus.i_rsv_en && bus.i_rsv_addr != 0)
                mdl_pend[bus.i_rsv_addr] = 1'b1;
        end
    endtask

    task automatic drive(input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input bit rsv, input logic [ADDR_W-1:0] ra,
                         input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2, input bit clr);
        bus.i_we = we;   bus.i_waddr = wa;   bus.i_wdata = wd;
        bus.i_rsv_en = rsv; bus.i_rsv_addr = ra;
        bus.i_raddr1 = r1; bus.i_raddr2 = r2; bus.i_clr = clr;
    endtask

    // One clock: compare outputs mid low-phase, then advance the model at the edge.
    task automatic cycle();
        #2;
        if (!rst_n) mdl_reset();
        chk("rdata1", bus.o_rdata1, exp_rd(bus.i_raddr1));
        chk("rdata2", bus.o_rdata2, exp_rd(bus.i_raddr2));
        chk("pend1",  bus.o_pend1,  exp_pend(bus.i_raddr1));
        chk("pend2",  bus.o_pend2,  exp_pend(bus.i_raddr2));
        chk("busy",   bus.o_busy,   mdl_clear_left > 0);
        @(posedge clk);
        mdl_edge();
        @(negedge clk);
    endtask

    task automatic count_busy(input string tag, input bit we_during);
        int n = 0;
        while (bus.o_busy && n < 100) begin
            drive(we_during, 5'd9, 32'hFFFF_FFFF, we_during, 5'd9, 5'd9, 5'd3, we_during);
            n++;
            cycle();
        end
        chk(tag, n, CLR_CYCLES);
    endtask

    initial begin
        logic [DATA_W-1:0] exp_v;
        logic              exp_b;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        mdl_reset();
        @(negedge clk);
        repeat (3) cycle();
        rst_n = 1'b1;
        count_busy("reset_clear_len", 1'b0);

        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 0, 0, 0, 5'(a), 5'(DEPTH - 1 - a), 0);
            cycle();
        end

        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 5'd5, 5'd5, 0); #1;
        chk("r5_port1", bus.o_rdata1, 32'hDEADBEEF);
        chk("r5_port2", bus.o_rdata2, 32'hDEADBEEF);
        cycle();
        drive(1, 5'd0, 32'h1234, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 5'd0, 5'd5, 0); #1;
        chk("r0_zero", bus.o_rdata1, 32'h0);
        cycle();

        drive(0, 0, 0, 1, 5'd7, 0, 0, 0); cycle();
        drive(1, 5'd7, 32'h77, 1, 5'd7, 5'd7, 0, 0); #1;
        chk("pend7_set", bus.o_pend1, 1'b1);
        cycle();
        drive(0, 0, 0, 0, 0, 5'd7, 0, 0); #1;
        chk("pend7_set_wins", bus.o_pend1, 1'b1);
        cycle();
        drive(1, 5'd7, 32'h78, 0, 0, 5'd7, 0, 0); #1;
`ifdef REGFILE_SB_BYPASS_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        chk("pend7_pre_wb", bus.o_pend1, exp_b);
        cycle();
        drive(0, 0, 0, 0, 0, 5'd7, 0, 0); #1;
        chk("pend7_cleared", bus.o_pend1, 1'b0);
        cycle();

        drive(1, 5'd3, 32'h1111_1111, 0, 0, 0, 0, 0); cycle();
        drive(1, 5'd3, 32'hA5A5_A5A5, 0, 0, 0, 5'd3, 0); #1;
`ifdef REGFILE_SB_BYPASS_EN
        exp_v = 32'hA5A5_A5A5;
`else
        exp_v = 32'h1111_1111;
`endif
        chk("bypass_same_cycle", bus.o_rdata2, exp_v);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 5'd3, 0); #1;
        chk("r3_next_cycle", bus.o_rdata2, 32'hA5A5_A5A5);
        cycle();

        drive(1, 5'd9, 32'h55, 1, 5'd9, 5'd9, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 5'd9, 0, 1); #1;
        chk("r9_before_clr", bus.o_rdata1, 32'h55);
        chk("pend9_before_clr", bus.o_pend1, 1'b1);
        cycle();
        count_busy("clr_len", 1'b1);
        drive(0, 0, 0, 0, 0, 5'd9, 0, 0); #1;
        chk("r9_after_clr", bus.o_rdata1, 32'h0);
        chk("pend9_after_clr", bus.o_pend1, 1'b0);
        cycle();

        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) cycle();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        count_busy("reset_mid_clr_len", 1'b0);

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(1, 0) == 1, 5'($urandom_range(DEPTH - 1, 0)), $urandom,
                  $urandom_range(9, 0) < 3, 5'($urandom_range(DEPTH - 1, 0)),
                  5'($urandom_range(DEPTH - 1, 0)), 5'($urandom_range(DEPTH - 1, 0)),
                  $urandom_range(249, 0) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 2R/1W pipeline register file: configurable data width and depth, optional hardwired zero register.
- Adds a hardware clear sequencer, because the storage array has no reset.
- Adds a per-register pending-write scoreboard, used by the decode stage for hazard stalls.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W (derived localparam).
- ZERO_REG, 1, when 1 register 0 always reads 0 and is never written or reserved.

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_clr  in  1  request full clear of array and scoreboard (sampled in IDLE only)
- i_raddr1  in  ADDR_W  read port 1 address
- i_raddr2  in  ADDR_W  read port 2 address
- i_waddr  in  ADDR_W  write address
- i_wdata  in  DATA_W  write data
- i_we  in  1  write enable
- i_rsv_en  in  1  reserve destination (instruction issued)
- i_rsv_addr  in  ADDR_W  register to mark pending
- o_rdata1  out  DATA_W  read data port 1 (combinational)
- o_rdata2  out  DATA_W  read data port 2 (combinational)
- o_pend1  out  1  pending bit of i_raddr1
- o_pend2  out  1  pending bit of i_raddr2
- o_busy  out  1  clear sequencer active

Behaviour:
- Reset, asynchronous, i_rst_n=0:
  - FSM=CLEAR, clear counter=ZERO_REG?1:0.
  - All pending bits=0; o_busy=1.
  - o_rdata1/2=0, o_pend1/2=0.
- FSM states:
  - IDLE: i_clr=1 at an edge -> CLEAR; counter reloads; all pending bits cleared on that edge.
  - CLEAR: each edge writes 0 to regs[counter] and increments counter. On the edge that writes DEPTH-1 -> IDLE.
  - Clear duration is DEPTH-ZERO_REG cycles (31 at defaults). o_busy=1 exactly while in CLEAR.
- During CLEAR:
  - i_we, i_rsv_en and i_clr are ignored.
  - o_rdata1/2 read 0; o_pend1/2 read 0.
- Reads (IDLE), combinational:
  - o_rdataN = regs[i_raddrN].
  - If ZERO_REG=1 and address=0, o_rdataN = 0.
  - Both ports may use the same address.
- Write (IDLE): i_we=1 -> regs[i_waddr] <= i_wdata at the edge. With ZERO_REG=1, waddr=0 is dropped.
- Scoreboard (IDLE), one bit per register:
  - i_rsv_en sets pend[i_rsv_addr] at the edge.
  - i_we clears pend[i_waddr] at the edge.
  - Simultaneous set and clear of the same address: set wins (the newer issue supersedes the older writeback).
  - Set and clear of different addresses both take effect.
  - ZERO_REG=1: pend[0] is constant 0.
  - Reserving an already pending register leaves it 1. Writing a non-pending register leaves it 0.
- o_pendN = pend[i_raddrN], combinational.
- Reset asserted mid-CLEAR restarts the sequence from the initial counter value.
- Arithmetic: counter is ADDR_W+1 bits wide, so there is no wrap at DEPTH-1. No data arithmetic.

Optional Feature:
- Macro REGFILE_SB_BYPASS_EN.
- Defined: write-to-read forwarding. In IDLE, if i_we=1 and i_waddr==i_raddrN (and address !=0 when ZERO_REG=1), o_rdataN = i_wdata in the same cycle.
  - o_pendN is also forced 0 in that case, unless i_rsv_en targets the same address, which keeps o_pendN=1.
- Undefined: reads return the pre-edge array value; new data is visible the cycle after the write edge; o_pendN reflects stored bits only.

Test Plan:
- Release reset -> o_busy=1 for exactly 31 edges, then 0. Then a read of every address returns 0x00000000 and o_pend1/2=0.
- IDLE: write 0xDEADBEEF to r5, next cycle raddr1=5, raddr2=5 -> both 0xDEADBEEF. Write 0x1234 to r0 -> raddr1=0 reads 0.
- rsv r7, next cycle raddr1=7 -> o_pend1=1.
  - Same cycle i_we to r7 and rsv r7 -> o_pend1 stays 1.
  - Next cycle i_we to r7 alone -> o_pend1=0.
- Bypass defined: i_we r3=0xA5A5A5A5 with raddr2=3 in the same cycle -> o_rdata2=0xA5A5A5A5 combinationally. Undefined -> old value, new value the next cycle.
- Clear and reset:
  - With r9=0x55 and r9 pending, pulse i_clr -> o_busy high 31 cycles; i_we to r9 during CLEAR is ignored. Afterwards r9 reads 0 and pend9=0.
  - Assert i_rst_n=0 at clear cycle 10 -> a full 31-cycle clear follows release.
